// File: rtl/keypad_scan_buf.sv
// 4x4 active-low keypad scanner with per-frame debounce and a 3-digit shift buffer.
// Accepted key codes enter at C and shift toward A; outputs feed the display stage directly.
module keypad_scan_buf #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  input  logic       clr,
  output logic [3:0] col,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

  // Row/column position to key code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = 4'd10;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = 4'd11;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = 4'd12;
      4'hC:    code = 4'd14;
      4'hD:    code = 4'd0;
      4'hE:    code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic          found_q;
  logic [3:0]    found_code_q;

  logic          slot_end_c;
  logic          frame_end_c;
  logic          row_hit_c;
  logic [1:0]    row_sel_c;
  logic [3:0]    row_code_c;
  logic          hit_c;
  logic [3:0]    code_c;

  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_c;

  assign slot_end_c  = (div_cnt == DIV_LAST);
  assign frame_end_c = slot_end_c && (col_idx == 2'd3);
  assign row_hit_c   = (row != 4'hF);

  // Lowest-numbered low row wins within the driven column.
  always_comb begin
    row_sel_c = 2'd3;
    if (!row[0])      row_sel_c = 2'd0;
    else if (!row[1]) row_sel_c = 2'd1;
    else if (!row[2]) row_sel_c = 2'd2;
  end

  assign row_code_c = key_map(row_sel_c, col_idx);

  // Frame result includes the last column's sample taken on the frame-end edge itself.
  assign hit_c  = found_q | row_hit_c;
  assign code_c = found_q ? found_code_q : row_code_c;

  // Column scan and first-hit capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      col_idx      <= 2'd0;
      col          <= 4'b1110;
      found_q      <= 1'b0;
      found_code_q <= 4'd0;
    end else begin
      if (slot_end_c) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[2:0], col[3]};
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (frame_end_c) begin
        found_q <= 1'b0;
      end else if (slot_end_c && !found_q && row_hit_c) begin
        found_q      <= 1'b1;
        found_code_q <= row_code_c;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce next-state; advances only on frame-end edges.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    if (frame_end_c) begin
      case (state_q)
        IDLE: begin
          if (hit_c) begin
            cand_d = code_c;
            if (DEBOUNCE <= 1) begin
              accept_c = 1'b1;
              state_d  = HELD;
              cnt_d    = '0;
            end else begin
              state_d = DEB;
              cnt_d   = CW'(1);
            end
          end
        end
        DEB: begin
          if (!hit_c) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (code_c != cand_q) begin
            cand_d = code_c;
            cnt_d  = CW'(1);
          end else if ((cnt_q + CW'(1)) >= DEB_MAX) begin
            accept_c = 1'b1;
            state_d  = HELD;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!hit_c) begin
            if (DEBOUNCE <= 1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = REL;
              cnt_d   = CW'(1);
            end
          end
        end
        REL: begin
          if (hit_c) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if ((cnt_q + CW'(1)) >= DEB_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Digit buffer; clr overrides a coincident accept but the key is still consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      A         <= 4'd0;
      B         <= 4'd0;
      C         <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (clr) begin
        A <= 4'd0;
        B <= 4'd0;
        C <= 4'd0;
      end else if (accept_c) begin
        A         <= B;
        B         <= C;
        C         <= code_c;
        key_code  <= code_c;
        key_valid <= 1'b1;
      end
    end
  end

endmodule
